// File: rtl/ex_stage_vliw.sv
//==== ex_stage_vliw : VLIW execute stage (NUM_ALU ALU lanes + MEM lane, bypass, EX/MEM register)
//==== rev 1.0
`default_nettype none

module ex_stage_vliw #(
  parameter int NUM_ALU = 2,
  parameter int DW      = 32,
  parameter int RW      = 3,
  parameter int NFWD    = 3,
  parameter int STW     = 8,
  localparam int SW     = $clog2(NFWD + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [NUM_ALU-1:0]     p2_alu_valid,
  input  logic [NUM_ALU-1:0]     p2_alu_regWrite,
  input  logic                   p2_alu_setFlags,
  input  logic [3*NUM_ALU-1:0]   p2_alu_op,
  input  logic [NUM_ALU-1:0]     p2_aluSrcB,
  input  logic [RW*NUM_ALU-1:0]  p2_alu_rd,
  input  logic [DW*NUM_ALU-1:0]  p2_alu_reg_rn,
  input  logic [DW*NUM_ALU-1:0]  p2_alu_reg_rm,
  input  logic [DW*NUM_ALU-1:0]  p2_alu_imm,
  input  logic [SW*NUM_ALU-1:0]  f_alu_rn_sel,
  input  logic [SW*NUM_ALU-1:0]  f_alu_rm_sel,
  input  logic                   p2_mem_valid,
  input  logic                   p2_memRead,
  input  logic                   p2_memWrite,
  input  logic                   p2_mem_regWrite,
  input  logic [RW-1:0]          p2_mem_rd,
  input  logic [DW-1:0]          p2_mem_reg_rn,
  input  logic [DW-1:0]          p2_mem_reg_rd,
  input  logic [DW-1:0]          p2_mem_imm,
  input  logic [SW-1:0]          f_mem_rn_sel,
  input  logic [SW-1:0]          f_mem_rd_sel,
  input  logic [DW*NFWD-1:0]     f_data,
  output logic [3:0]             flags,
  output logic [NUM_ALU-1:0]     p3_alu_valid,
  output logic [NUM_ALU-1:0]     p3_alu_regWrite,
  output logic [RW*NUM_ALU-1:0]  p3_alu_rd,
  output logic [DW*NUM_ALU-1:0]  p3_alu_out,
  output logic                   p3_mem_valid,
  output logic                   p3_memRead,
  output logic                   p3_memWrite,
  output logic                   p3_mem_regWrite,
  output logic [RW-1:0]          p3_mem_rd,
  output logic [DW-1:0]          p3_mem_address,
  output logic [STW-1:0]         p3_mem_store
);

  localparam int SH = $clog2(DW);

  // Selects above NFWD fall back to the register-file value.
  function automatic logic [DW-1:0] fwd(input logic [SW-1:0]      sel,
                                        input logic [DW-1:0]      regv,
                                        input logic [DW*NFWD-1:0] src);
    logic [DW-1:0] r;
    r = regv;
    for (int k = 1; k <= NFWD; k++)
      if (sel == SW'(k)) r = src[(k-1)*DW +: DW];
    return r;
  endfunction

  logic [DW*NUM_ALU-1:0] alu_res;
  logic [NUM_ALU-1:0]    lane_c;
  logic [NUM_ALU-1:0]    lane_v;
  logic [NUM_ALU-1:0]    lane_cv;

  for (genvar i = 0; i < NUM_ALU; i++) begin : g_alu
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic [DW:0]   sum;
    logic [DW:0]   dif;
    logic          c;
    logic          v;
    logic          cv;

    always_comb begin
      a   = fwd(f_alu_rn_sel[i*SW +: SW], p2_alu_reg_rn[i*DW +: DW], f_data);
      b   = p2_aluSrcB[i] ? p2_alu_imm[i*DW +: DW]
                          : fwd(f_alu_rm_sel[i*SW +: SW], p2_alu_reg_rm[i*DW +: DW], f_data);
      sum = {1'b0, a} + {1'b0, b};
      // Carry out of a + ~b + 1 is the no-borrow flag.
      dif = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
      res = '0;
      c   = 1'b0;
      v   = 1'b0;
      cv  = 1'b0;
      case (p2_alu_op[i*3 +: 3])
        3'd0: begin
          res = sum[DW-1:0];
          c   = sum[DW];
          v   = (a[DW-1] == b[DW-1]) && (res[DW-1] != a[DW-1]);
          cv  = 1'b1;
        end
        3'd1: begin
          res = dif[DW-1:0];
          c   = dif[DW];
          v   = (a[DW-1] != b[DW-1]) && (res[DW-1] != a[DW-1]);
          cv  = 1'b1;
        end
        3'd2:    res = a & b;
        3'd3:    res = a | b;
        3'd4:    res = a ^ b;
        3'd5:    res = a << b[SH-1:0];
        3'd6:    res = a >> b[SH-1:0];
        default: res = b;
      endcase
    end

    assign alu_res[i*DW +: DW] = res;
    assign lane_c[i]           = c;
    assign lane_v[i]           = v;
    assign lane_cv[i]          = cv;
  end

  logic [3:0]    flags_nxt;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_store_full;

  always_comb begin
    flags_nxt = flags;
    if (p2_alu_valid[0] && p2_alu_setFlags) begin
      flags_nxt[3] = alu_res[DW-1];
      flags_nxt[2] = (alu_res[DW-1:0] == '0);
      if (lane_cv[0]) begin
        flags_nxt[1] = lane_c[0];
        flags_nxt[0] = lane_v[0];
      end
    end
  end

  assign mem_addr       = fwd(f_mem_rn_sel, p2_mem_reg_rn, f_data) + p2_mem_imm;
  assign mem_store_full = fwd(f_mem_rd_sel, p2_mem_reg_rd, f_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      flags           <= '0;
      p3_alu_valid    <= '0;
      p3_alu_regWrite <= '0;
      p3_alu_rd       <= '0;
      p3_alu_out      <= '0;
      p3_mem_valid    <= 1'b0;
      p3_memRead      <= 1'b0;
      p3_memWrite     <= 1'b0;
      p3_mem_regWrite <= 1'b0;
      p3_mem_rd       <= '0;
      p3_mem_address  <= '0;
      p3_mem_store    <= '0;
    end else if (flush) begin
      // Bubble: control bits cleared, data fields and flags left as they are.
      p3_alu_valid    <= '0;
      p3_alu_regWrite <= '0;
      p3_mem_valid    <= 1'b0;
      p3_memRead      <= 1'b0;
      p3_memWrite     <= 1'b0;
      p3_mem_regWrite <= 1'b0;
    end else if (!stall) begin
      flags           <= flags_nxt;
      p3_alu_valid    <= p2_alu_valid;
      p3_alu_regWrite <= p2_alu_regWrite & p2_alu_valid;
      p3_alu_rd       <= p2_alu_rd;
      p3_alu_out      <= alu_res;
      p3_mem_valid    <= p2_mem_valid;
      p3_memRead      <= p2_memRead & p2_mem_valid;
      p3_memWrite     <= p2_memWrite & p2_mem_valid;
      p3_mem_regWrite <= p2_mem_regWrite & p2_mem_valid;
      p3_mem_rd       <= p2_mem_rd;
      p3_mem_address  <= mem_addr;
      p3_mem_store    <= mem_store_full[STW-1:0];
    end
  end

endmodule

`default_nettype wire
